// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Merges two register-file write sources onto one write port.
//   Port 0 (WE0/A0/WD0): pipeline writeback. It has the highest priority and
//     is never back-pressured.
//   Port 1 (Valid1/Ready1/A1W/WD1): multicycle unit. Its writes are held in a
//     2-entry in-order FIFO and drain whenever port 0 is idle.
//   Write port: WE3/A3/WD3.
//   Hazard check: RA1/RA2 in, Hit1/Hit2 out. A hit means the register has a
//     queued write that has not reached the register file yet.
//   StallReq: asks the pipeline for a bubble so the queue can drain.
//   Count: number of queued entries.
// Register 15 is not writable: writes addressed to it are dropped.
// Reset is synchronous and active-low.
module reg_write_arbiter (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        WE0,
    input  logic [3:0]  A0,
    input  logic [31:0] WD0,
    input  logic        Valid1,
    output logic        Ready1,
    input  logic [3:0]  A1W,
    input  logic [31:0] WD1,
    output logic        WE3,
    output logic [3:0]  A3,
    output logic [31:0] WD3,
    input  logic [3:0]  RA1,
    input  logic [3:0]  RA2,
    output logic        Hit1,
    output logic        Hit2,
    output logic        StallReq,
    output logic [1:0]  Count
);

    logic [1:0][3:0]  r_ent_a;
    logic [1:0][31:0] r_ent_d;
    logic [1:0]       r_count;
    logic [1:0]       r_starve;

    logic             w_p0;
    logic             w_pend;
    logic             w_pop;
    logic             w_enq;
    logic [1:0][3:0]  w_nxt_a;
    logic [1:0][31:0] w_nxt_d;
    logic [1:0]       w_nxt_cnt;
    logic             w_keep0;
    logic             w_keep1;

    assign w_p0   = Reset_n && WE0 && (A0 != 4'd15);
    assign w_pend = Reset_n && (r_count != 2'd0);
    assign w_pop  = w_pend && !w_p0;
    assign Ready1 = Reset_n && (r_count < 2'd2);
    // The handshake completes for register 15 too; only the enqueue is dropped.
    assign w_enq  = Valid1 && Ready1 && (A1W != 4'd15);

    assign WE3 = w_p0 || w_pend;
    assign A3  = w_p0 ? A0  : (w_pend ? r_ent_a[0] : 4'd0);
    assign WD3 = w_p0 ? WD0 : (w_pend ? r_ent_d[0] : 32'd0);

    assign Count    = Reset_n ? r_count : 2'd0;
    assign StallReq = Reset_n && ((r_starve == 2'd3) || (r_count == 2'd2));
    assign Hit1 = Reset_n && (RA1 != 4'd15) &&
                  (((r_count != 2'd0) && (r_ent_a[0] == RA1)) ||
                   ((r_count == 2'd2) && (r_ent_a[1] == RA1)));
    assign Hit2 = Reset_n && (RA2 != 4'd15) &&
                  (((r_count != 2'd0) && (r_ent_a[0] == RA2)) ||
                   ((r_count == 2'd2) && (r_ent_a[1] == RA2)));

    // Next queue contents are built in three steps: pop, then squash, then
    // enqueue. A pop and a squash never happen in the same cycle.
    // The squash keeps the survivors in order. The new entry is appended
    // after the squash, because it is younger than the port-0 write.
    assign w_keep0 = (r_count != 2'd0) && !(w_p0 && (r_ent_a[0] == A0));
    assign w_keep1 = (r_count == 2'd2) && !(w_p0 && (r_ent_a[1] == A0));

    always_comb begin
        w_nxt_a   = r_ent_a;
        w_nxt_d   = r_ent_d;
        w_nxt_cnt = r_count;
        if (w_pop) begin
            w_nxt_a[0] = r_ent_a[1];
            w_nxt_d[0] = r_ent_d[1];
            w_nxt_cnt  = r_count - 2'd1;
        end else if (w_p0) begin
            w_nxt_cnt = {1'b0, w_keep0} + {1'b0, w_keep1};
            if (!w_keep0) begin
                w_nxt_a[0] = r_ent_a[1];
                w_nxt_d[0] = r_ent_d[1];
            end
        end
        // There is always a free slot here: Ready1 requires count < 2, and
        // a pop or a squash can only lower the count.
        if (w_enq) begin
            w_nxt_a[w_nxt_cnt[0]] = A1W;
            w_nxt_d[w_nxt_cnt[0]] = WD1;
            w_nxt_cnt             = w_nxt_cnt + 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_count  <= 2'd0;
            r_starve <= 2'd0;
            r_ent_a  <= '0;
            r_ent_d  <= '0;
        end else begin
            r_count <= w_nxt_cnt;
            r_ent_a <= w_nxt_a;
            r_ent_d <= w_nxt_d;
            // With a non-empty queue, each cycle is either a port-0 win or a
            // pop, so this expression also clears the counter on every pop.
            if (w_pend && w_p0)
                r_starve <= (r_starve == 2'd3) ? 2'd3 : r_starve + 2'd1;
            else
                r_starve <= 2'd0;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        WE0;
    logic [3:0]  A0;
    logic [31:0] WD0;
    logic        Valid1;
    logic        Ready1;
    logic [3:0]  A1W;
    logic [31:0] WD1;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [3:0]  RA1;
    logic [3:0]  RA2;
    logic        Hit1;
    logic        Hit2;
    logic        StallReq;
    logic [1:0]  Count;

    int vectors = 0;
    int miscompares = 0;

    reg_write_arbiter dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .WE0(WE0), .A0(A0), .WD0(WD0),
        .Valid1(Valid1), .Ready1(Ready1), .A1W(A1W), .WD1(WD1),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .RA1(RA1), .RA2(RA2), .Hit1(Hit1), .Hit2(Hit2),
        .StallReq(StallReq), .Count(Count)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 ns after a rising edge. Outputs are checked 1 ns after
    // that, well away from the next edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        WE0 = 0; A0 = 0; WD0 = 0; Valid1 = 0; A1W = 0; WD1 = 0;
    endtask

    task automatic test_reset();
        Reset_n = 0; idle(); RA1 = 4'd0; RA2 = 4'd0;
        step(); step();
        WE0 = 1; A0 = 4'd2; Valid1 = 1; A1W = 4'd3; settle();
        vectors++; if (WE3 !== 1'b0) begin miscompares++; $display("FAIL rst_we3 got=%0h exp=0", WE3); end
        vectors++; if (Ready1 !== 1'b0) begin miscompares++; $display("FAIL rst_ready1 got=%0h exp=0", Ready1); end
        vectors++; if (Count !== 2'd0) begin miscompares++; $display("FAIL rst_count got=%0d exp=0", Count); end
        vectors++; if (StallReq !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%0h exp=0", StallReq); end
        step();
        idle(); Reset_n = 1; settle();
        vectors++; if (Ready1 !== 1'b1) begin miscompares++; $display("FAIL rst_rel_ready1 got=%0h exp=1", Ready1); end
        vectors++; if (Count !== 2'd0) begin miscompares++; $display("FAIL rst_rel_count got=%0d exp=0", Count); end
        vectors++; if (WE3 !== 1'b0 || A3 !== 4'd0 || WD3 !== 32'd0) begin miscompares++; $display("FAIL rst_rel_port got=%0h/%0h/%0h exp=0/0/0", WE3, A3, WD3); end
    endtask

    task automatic test_single();
        Valid1 = 1; A1W = 4'd3; WD1 = 32'hA5A5A5A5; settle();
        vectors++; if (WE3 !== 1'b0) begin miscompares++; $display("FAIL single_nobypass got=%0h exp=0", WE3); end
        step(); idle(); settle();
        vectors++; if (WE3 !== 1'b1 || A3 !== 4'd3 || WD3 !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL single_write got=%0h/%0h/%0h exp=1/3/a5a5a5a5", WE3, A3, WD3); end
        vectors++; if (Count !== 2'd1) begin miscompares++; $display("FAIL single_count1 got=%0d exp=1", Count); end
        step(); settle();
        vectors++; if (Count !== 2'd0 || WE3 !== 1'b0) begin miscompares++; $display("FAIL single_drained got=%0d/%0h exp=0/0", Count, WE3); end
    endtask

    task automatic test_full();
        WE0 = 1; A0 = 4'd6; WD0 = 32'h66; Valid1 = 1; A1W = 4'd4; WD1 = 32'h44; settle();
        vectors++; if (WE3 !== 1'b1 || A3 !== 4'd6 || WD3 !== 32'h66) begin miscompares++; $display("FAIL full_p0 got=%0h/%0h/%0h exp=1/6/66", WE3, A3, WD3); end
        step(); A1W = 4'd5; WD1 = 32'h55; settle();
        vectors++; if (Count !== 2'd1) begin miscompares++; $display("FAIL full_count1 got=%0d exp=1", Count); end
        step(); Valid1 = 0; settle();
        vectors++; if (Count !== 2'd2 || Ready1 !== 1'b0 || StallReq !== 1'b1) begin miscompares++; $display("FAIL full_state got=%0d/%0h/%0h exp=2/0/1", Count, Ready1, StallReq); end
        vectors++; if (WE3 !== 1'b1 || A3 !== 4'd6) begin miscompares++; $display("FAIL full_p0_wins got=%0h/%0h exp=1/6", WE3, A3); end
        step(); idle(); settle();
        vectors++; if (WE3 !== 1'b1 || A3 !== 4'd4 || WD3 !== 32'h44) begin miscompares++; $display("FAIL full_drain4 got=%0h/%0h/%0h exp=1/4/44", WE3, A3, WD3); end
        step(); settle();
        vectors++; if (WE3 !== 1'b1 || A3 !== 4'd5 || WD3 !== 32'h55) begin miscompares++; $display("FAIL full_drain5 got=%0h/%0h/%0h exp=1/5/55", WE3, A3, WD3); end
        step(); settle();
        vectors++; if (Count !== 2'd0 || WE3 !== 1'b0) begin miscompares++; $display("FAIL full_empty got=%0d/%0h exp=0/0", Count, WE3); end
    endtask

    task automatic test_squash();
        WE0 = 1; A0 = 4'd8; WD0 = 32'h88; Valid1 = 1; A1W = 4'd7; WD1 = 32'h11;
        step(); Valid1 = 0; A0 = 4'd7; WD0 = 32'h22; RA1 = 4'd7; settle();
        vectors++; if (WE3 !== 1'b1 || A3 !== 4'd7 || WD3 !== 32'h22) begin miscompares++; $display("FAIL squash_p0 got=%0h/%0h/%0h exp=1/7/22", WE3, A3, WD3); end
        vectors++; if (Hit1 !== 1'b1) begin miscompares++; $display("FAIL squash_hit1 got=%0h exp=1", Hit1); end
        step(); idle(); settle();
        vectors++; if (Count !== 2'd0 || WE3 !== 1'b0 || Hit1 !== 1'b0) begin miscompares++; $display("FAIL squash_gone got=%0d/%0h/%0h exp=0/0/0", Count, WE3, Hit1); end
        // Squash the older of two entries; the younger one must survive.
        WE0 = 1; A0 = 4'd1; Valid1 = 1; A1W = 4'd4; WD1 = 32'h40;
        step(); A0 = 4'd2; A1W = 4'd5; WD1 = 32'h50;
        step(); Valid1 = 0; A0 = 4'd4; RA2 = 4'd5;
        settle();
        vectors++; if (Hit2 !== 1'b1) begin miscompares++; $display("FAIL squash_hit2 got=%0h exp=1", Hit2); end
        step(); idle(); settle();
        vectors++; if (Count !== 2'd1 || A3 !== 4'd5 || WD3 !== 32'h50) begin miscompares++; $display("FAIL squash_order got=%0d/%0h/%0h exp=1/5/50", Count, A3, WD3); end
        step(); RA1 = 4'd0; RA2 = 4'd0;
        // Old entry to 10 squashed; same-cycle enqueue to 10 is kept.
        WE0 = 1; A0 = 4'd0; Valid1 = 1; A1W = 4'd10; WD1 = 32'h1;
        step(); A0 = 4'd10; WD0 = 32'h2; WD1 = 32'h3;
        step(); idle(); settle();
        vectors++; if (Count !== 2'd1 || A3 !== 4'd10 || WD3 !== 32'h3) begin miscompares++; $display("FAIL squash_young got=%0d/%0h/%0h exp=1/a/3", Count, A3, WD3); end
        step(); settle();
    endtask

    task automatic test_reg15();
        WE0 = 1; A0 = 4'd15; WD0 = 32'hF0; Valid1 = 1; A1W = 4'd15; WD1 = 32'hF1; RA1 = 4'd15; settle();
        vectors++; if (WE3 !== 1'b0 || Ready1 !== 1'b1) begin miscompares++; $display("FAIL r15_now got=%0h/%0h exp=0/1", WE3, Ready1); end
        step(); idle(); settle();
        vectors++; if (WE3 !== 1'b0 || Count !== 2'd0 || Hit1 !== 1'b0) begin miscompares++; $display("FAIL r15_after got=%0h/%0d/%0h exp=0/0/0", WE3, Count, Hit1); end
        RA1 = 4'd0;
    endtask

    task automatic test_starve();
        logic [3:0] exp_stall;
        exp_stall = 4'b1000;
        WE0 = 1; A0 = 4'd1; Valid1 = 1; A1W = 4'd9; WD1 = 32'h99;
        step(); Valid1 = 0;
        for (int i = 0; i < 4; i++) begin
            A0 = 4'(i + 2); settle();
            vectors++; if (StallReq !== exp_stall[i]) begin miscompares++; $display("FAIL starve_win%0d got=%0h exp=%0h", i + 1, StallReq, exp_stall[i]); end
            step();
        end
        idle(); settle();
        vectors++; if (StallReq !== 1'b1 || A3 !== 4'd9 || WD3 !== 32'h99) begin miscompares++; $display("FAIL starve_drain got=%0h/%0h/%0h exp=1/9/99", StallReq, A3, WD3); end
        step(); settle();
        vectors++; if (StallReq !== 1'b0 || Count !== 2'd0) begin miscompares++; $display("FAIL starve_clear got=%0h/%0d exp=0/0", StallReq, Count); end
    endtask

    task automatic test_back_to_back();
        Valid1 = 1; A1W = 4'd1; WD1 = 32'h100;
        step(); A1W = 4'd2; WD1 = 32'h200; settle();
        vectors++; if (A3 !== 4'd1 || Count !== 2'd1 || Ready1 !== 1'b1) begin miscompares++; $display("FAIL b2b_first got=%0h/%0d/%0h exp=1/1/1", A3, Count, Ready1); end
        step(); idle(); settle();
        vectors++; if (A3 !== 4'd2 || WD3 !== 32'h200 || Count !== 2'd1) begin miscompares++; $display("FAIL b2b_second got=%0h/%0h/%0d exp=2/200/1", A3, WD3, Count); end
        step(); settle();
        vectors++; if (Count !== 2'd0) begin miscompares++; $display("FAIL b2b_empty got=%0d exp=0", Count); end
    endtask

    task automatic test_reset_mid();
        WE0 = 1; A0 = 4'd6; Valid1 = 1; A1W = 4'd4; WD1 = 32'h4;
        step(); A1W = 4'd5;
        step(); Valid1 = 0; RA1 = 4'd4; settle();
        vectors++; if (Count !== 2'd2 || Hit1 !== 1'b1) begin miscompares++; $display("FAIL rmid_pre got=%0d/%0h exp=2/1", Count, Hit1); end
        Reset_n = 0; settle();
        vectors++; if (Count !== 2'd0 || Hit1 !== 1'b0 || WE3 !== 1'b0 || StallReq !== 1'b0) begin miscompares++; $display("FAIL rmid_in got=%0d/%0h/%0h/%0h exp=0/0/0/0", Count, Hit1, WE3, StallReq); end
        step(); Reset_n = 1; idle(); settle();
        vectors++; if (Count !== 2'd0 || Hit1 !== 1'b0 || WE3 !== 1'b0 || Ready1 !== 1'b1) begin miscompares++; $display("FAIL rmid_post got=%0d/%0h/%0h/%0h exp=0/0/0/1", Count, Hit1, WE3, Ready1); end
        RA1 = 4'd0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_squash();
        test_reg15();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
